alu_arbiter: RTL

//  Shares one combinational ALU (3-bit alu_control encoding from alu_decoder) between two requesters:

---
 rtl/alu_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with a one-entry response slot.
// Optional grant counters are enabled by defining ALU_ARB_PERF_EN.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] req_a0,
    input  logic [DATA_WIDTH-1:0] req_b0,
    input  logic [2:0]            req_ctrl0,
    input  logic [DATA_WIDTH-1:0] req_a1,
    input  logic [DATA_WIDTH-1:0] req_b1,
    input  logic [2:0]            req_ctrl1,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic [CNT_WIDTH-1:0]  perf_grant0,
    output logic [CNT_WIDTH-1:0]  perf_grant1
);

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   grant_vld;
    logic   grant_id;
    logic   can_accept;
    logic   hs;

    // Stage 0: arbitration, ALU operand steering and next-state decode
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (req_valid)
            2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;        end
            2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;        end
            2'b11:   begin grant_vld = 1'b1; grant_id = ~last_grant; end
            default: ;
        endcase

        // Reset masks acceptance so no requester sees a handshake while rst is high
        can_accept = !rst && ((state == S_IDLE) || (rsp_ready && state == S_HOLD));

        req_ready = 2'b00;
        if (grant_vld && can_accept) req_ready[grant_id] = 1'b1;
        hs = |(req_valid & req_ready);

        alu_a    = grant_id ? req_a1    : req_a0;
        alu_b    = grant_id ? req_b1    : req_b0;
        alu_ctrl = grant_id ? req_ctrl1 : req_ctrl0;

        state_nxt = state;
        if (hs)                                 state_nxt = S_HOLD;
        else if (state == S_HOLD && rsp_ready)  state_nxt = S_IDLE;
    end

    // Stage 1: response slot
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    assign rsp_valid = (state == S_HOLD);

`ifdef ALU_ARB_PERF_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
        end else if (hs) begin
            if (grant_id) perf_grant1 <= sat_inc(perf_grant1);
            else          perf_grant0 <= sat_inc(perf_grant0);
        end
    end
`else
    assign perf_grant0 = '0;
    assign perf_grant1 = '0;
`endif

endmodule
